// File: rtl/gamma_lut_scheduler.sv
// Gamma LUT write scheduler: queues CPU writes into the idle 4th slot of each colour group
// and defers gamma page/bypass changes to a vsync falling edge (or a no-video timeout).
module gamma_lut_scheduler #(
  parameter int         color_width_i = 7,
  parameter int         PAGE_BITS     = 3,
  parameter int         FIFO_DEPTH    = 4,
  parameter logic [3:0] GAMMA_OFF     = 4'h5,
  parameter int         TIMEOUT_W     = 20
) (
  input  logic                                 VCLK,
  input  logic                                 nRST,
  input  logic                                 vdata_valid_i,
  input  logic                                 vsync_i,
  input  logic [3:0]                           gammaparams_i,
  input  logic                                 wr_req_i,
  input  logic [PAGE_BITS+color_width_i-1:0]   wr_addr_i,
  input  logic [color_width_i-1:0]             wr_data_i,
  output logic                                 wr_ready_o,
  output logic                                 lut_we_o,
  output logic [PAGE_BITS+color_width_i-1:0]   lut_waddr_o,
  output logic [color_width_i-1:0]             lut_wdata_o,
  output logic [PAGE_BITS-1:0]                 gamma_page_o,
  output logic                                 en_gamma_boost_o,
  output logic                                 switch_pend_o
);

  localparam int AW = PAGE_BITS + color_width_i;
  localparam int EW = AW + color_width_i;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    APPLY   = 2'd2
  } state_t;

  logic [1:0]           slot_cnt;
  logic                 free_slot;

  logic [EW-1:0]        fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [CW-1:0]        fifo_cnt;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 push;
  logic                 pop;

  state_t               state;
  logic [3:0]           req_params;
  logic [3:0]           applied_params;
  logic [TIMEOUT_W-1:0] timeout_cnt;
  logic                 timeout_hit;
  logic                 vsync_prev;
  logic                 vsync_fall;
  logic [PAGE_BITS-1:0] page_next;

  // Slot 1 follows the R-slot marker; slot 3 without a new marker is the LUT's idle slot.
  always_ff @(posedge VCLK) begin
    if (!nRST) begin
      slot_cnt <= 2'd0;
    end else if (vdata_valid_i) begin
      slot_cnt <= 2'd1;
    end else begin
      slot_cnt <= slot_cnt + 2'd1;
    end
  end

  assign free_slot  = (slot_cnt == 2'd3) && !vdata_valid_i;

  assign fifo_full  = (fifo_cnt == CW'(FIFO_DEPTH));
  assign fifo_empty = (fifo_cnt == '0);

  assign wr_ready_o = nRST && !fifo_full;
  assign push       = wr_req_i && wr_ready_o;
  assign lut_we_o   = nRST && !fifo_empty && free_slot;
  assign pop        = lut_we_o;

  assign {lut_waddr_o, lut_wdata_o} = fifo_mem[rd_ptr];

  always_ff @(posedge VCLK) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {wr_addr_i, wr_data_i};
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge VCLK) begin
    if (!nRST) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  assign vsync_fall  = vdata_valid_i && vsync_prev && !vsync_i;
  assign timeout_hit = &timeout_cnt;

  // A fresh request or a revert always wins over a same-cycle vsync edge.
  always_ff @(posedge VCLK) begin
    if (!nRST) begin
      state          <= IDLE;
      req_params     <= GAMMA_OFF;
      applied_params <= GAMMA_OFF;
      timeout_cnt    <= '0;
      vsync_prev     <= 1'b0;
      switch_pend_o  <= 1'b0;
    end else begin
      if (vdata_valid_i) begin
        vsync_prev <= vsync_i;
      end
      case (state)
        IDLE: begin
          if (vdata_valid_i) begin
            timeout_cnt <= '0;
          end
          if (gammaparams_i != applied_params) begin
            req_params    <= gammaparams_i;
            timeout_cnt   <= '0;
            switch_pend_o <= 1'b1;
            state         <= PENDING;
          end
        end
        PENDING: begin
          if (vdata_valid_i) begin
            timeout_cnt <= '0;
          end else begin
            timeout_cnt <= timeout_cnt + TIMEOUT_W'(1);
          end
          if (gammaparams_i == applied_params) begin
            switch_pend_o <= 1'b0;
            state         <= IDLE;
          end else if (gammaparams_i != req_params) begin
            req_params <= gammaparams_i;
          end else if (vsync_fall || timeout_hit) begin
            state <= APPLY;
          end
        end
        APPLY: begin
          applied_params <= req_params;
          switch_pend_o  <= 1'b0;
          state          <= IDLE;
        end
        default: begin
          switch_pend_o <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

  // Codes above the bypass code shift down by one; in bypass the page is parked at 0.
  always_comb begin
    page_next = '0;
    if (applied_params < GAMMA_OFF) begin
      page_next = PAGE_BITS'(applied_params);
    end else if (applied_params > GAMMA_OFF) begin
      page_next = PAGE_BITS'(applied_params - 4'd1);
    end
  end

  always_ff @(posedge VCLK) begin
    if (!nRST) begin
      gamma_page_o     <= '0;
      en_gamma_boost_o <= 1'b0;
    end else begin
      gamma_page_o     <= page_next;
      en_gamma_boost_o <= (applied_params != GAMMA_OFF);
    end
  end

endmodule

// File: tb/tb_gamma_lut_scheduler.sv
// Directed bench for gamma_lut_scheduler: a negedge reference model scores every LUT write
// and the ready/strobe outputs, while the main sequence checks reset, slotting and page switching.
module tb_gamma_lut_scheduler;

  localparam int CWID  = 7;
  localparam int PB    = 3;
  localparam int AW    = PB + CWID;
  localparam int DEPTH = 4;
  localparam int TW    = 4;

  logic            VCLK = 1'b0;
  logic            nRST;
  logic            vdata_valid_i = 1'b0;
  logic            vsync_i;
  logic [3:0]      gammaparams_i;
  logic            wr_req_i;
  logic [AW-1:0]   wr_addr_i;
  logic [CWID-1:0] wr_data_i;
  logic            wr_ready_o;
  logic            lut_we_o;
  logic [AW-1:0]   lut_waddr_o;
  logic [CWID-1:0] lut_wdata_o;
  logic [PB-1:0]   gamma_page_o;
  logic            en_gamma_boost_o;
  logic            switch_pend_o;

  int vectors     = 0;
  int errors      = 0;
  int writes_seen = 0;
  int vid_period  = 0;
  int vcnt        = 0;

  logic [AW+CWID-1:0] sb [$];
  logic [1:0]         mslot = 2'd0;
  logic               m_exp_we;
  logic               m_exp_ready;
  logic [AW+CWID-1:0] m_head;

  gamma_lut_scheduler #(
    .color_width_i (CWID),
    .PAGE_BITS     (PB),
    .FIFO_DEPTH    (DEPTH),
    .GAMMA_OFF     (4'h5),
    .TIMEOUT_W     (TW)
  ) dut (
    .VCLK             (VCLK),
    .nRST             (nRST),
    .vdata_valid_i    (vdata_valid_i),
    .vsync_i          (vsync_i),
    .gammaparams_i    (gammaparams_i),
    .wr_req_i         (wr_req_i),
    .wr_addr_i        (wr_addr_i),
    .wr_data_i        (wr_data_i),
    .wr_ready_o       (wr_ready_o),
    .lut_we_o         (lut_we_o),
    .lut_waddr_o      (lut_waddr_o),
    .lut_wdata_o      (lut_wdata_o),
    .gamma_page_o     (gamma_page_o),
    .en_gamma_boost_o (en_gamma_boost_o),
    .switch_pend_o    (switch_pend_o)
  );

  always #5 VCLK = ~VCLK;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge VCLK);
    #1;
  endtask

  // Holds a write request until the DUT accepts it.
  task automatic applyStimulus(input logic [AW-1:0] addr, input logic [CWID-1:0] data);
    logic acc;
    acc       = 1'b0;
    wr_addr_i = addr;
    wr_data_i = data;
    wr_req_i  = 1'b1;
    for (int i = 0; i < 64 && !acc; i++) begin
      @(negedge VCLK);
      acc = wr_ready_o;
      @(posedge VCLK);
      #1;
    end
    wr_req_i = 1'b0;
    if (!acc) checkOutput("push_accept", 32'(acc), 32'd1);
  endtask

  // Presents one valid group with vsync high, then returns just after the edge sampling vsync low.
  task automatic vsyncFall();
    int n;
    vsync_i = 1'b1;
    n = 0;
    @(negedge VCLK);
    while (!vdata_valid_i && n < 20) begin
      @(negedge VCLK);
      n++;
    end
    if (!vdata_valid_i) checkOutput("vsync_hi_wait", 32'(vdata_valid_i), 32'd1);
    @(posedge VCLK);
    n = 0;
    @(negedge VCLK);
    while (!vdata_valid_i && n < 20) begin
      @(negedge VCLK);
      n++;
    end
    if (!vdata_valid_i) checkOutput("vsync_lo_wait", 32'(vdata_valid_i), 32'd1);
    vsync_i = 1'b0;
    @(posedge VCLK);
    #1;
  endtask

  always @(posedge VCLK) begin
    #1;
    if (vid_period == 0) begin
      vdata_valid_i = 1'b0;
      vcnt          = 0;
    end else begin
      vdata_valid_i = (vcnt == 0);
      vcnt          = (vcnt + 1 >= vid_period) ? 0 : vcnt + 1;
    end
  end

  // Reference model of slot counter and write queue, evaluated just before each active edge.
  always @(negedge VCLK) begin
    m_exp_ready = nRST && (sb.size() < DEPTH);
    m_exp_we    = nRST && (sb.size() != 0) && (mslot == 2'd3) && !vdata_valid_i;
    checkOutput("wr_ready", 32'(wr_ready_o), 32'(m_exp_ready));
    checkOutput("lut_we", 32'(lut_we_o), 32'(m_exp_we));
    if (lut_we_o && sb.size() != 0) begin
      m_head = sb.pop_front();
      writes_seen++;
      checkOutput("lut_addr_data", 32'({lut_waddr_o, lut_wdata_o}), 32'(m_head));
    end
    if (wr_req_i && m_exp_ready) sb.push_back({wr_addr_i, wr_data_i});
    if (!nRST) begin
      sb.delete();
      mslot = 2'd0;
    end else if (vdata_valid_i) begin
      mslot = 2'd1;
    end else begin
      mslot = mslot + 2'd1;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before 500000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    nRST          = 1'b0;
    wr_req_i      = 1'b1;
    wr_addr_i     = 10'h3FF;
    wr_data_i     = 7'h7F;
    vsync_i       = 1'b1;
    gammaparams_i = 4'h5;

    // T1: reset with a request held
    tick(5);
    checkOutput("rst_ready", 32'(wr_ready_o), 32'd0);
    checkOutput("rst_we", 32'(lut_we_o), 32'd0);
    checkOutput("rst_boost", 32'(en_gamma_boost_o), 32'd0);
    checkOutput("rst_page", 32'(gamma_page_o), 32'd0);
    checkOutput("rst_pend", 32'(switch_pend_o), 32'd0);
    nRST     = 1'b1;
    wr_req_i = 1'b0;
    #1;
    checkOutput("rel_ready", 32'(wr_ready_o), 32'd1);
    tick(2);
    checkOutput("rel_page", 32'(gamma_page_o), 32'd0);
    checkOutput("rel_boost", 32'(en_gamma_boost_o), 32'd0);

    // T2: one write per 4-cycle group
    vid_period = 4;
    tick(6);
    base = writes_seen;
    applyStimulus(10'h005, 7'h11);
    applyStimulus(10'h105, 7'h22);
    applyStimulus(10'h205, 7'h33);
    tick(24);
    checkOutput("t2_writes", 32'(writes_seen - base), 32'd3);
    checkOutput("t2_drained", 32'(sb.size()), 32'd0);

    // T3: fill with no free slots, then drain
    vid_period = 3;
    tick(8);
    base = writes_seen;
    for (int i = 0; i < 4; i++) applyStimulus(AW'(10'h010 + i), CWID'(7'h40 + i));
    tick(2);
    checkOutput("t3_full_ready", 32'(wr_ready_o), 32'd0);
    checkOutput("t3_no_issue", 32'(writes_seen - base), 32'd0);
    vid_period = 4;
    applyStimulus(10'h3A4, 7'h55);
    applyStimulus(10'h1C3, 7'h2A);
    tick(40);
    checkOutput("t3_writes", 32'(writes_seen - base), 32'd6);
    checkOutput("t3_drained", 32'(sb.size()), 32'd0);

    // T4: 5 -> 2 waits for vsync
    gammaparams_i = 4'h2;
    tick(2);
    checkOutput("t4_pend", 32'(switch_pend_o), 32'd1);
    checkOutput("t4_page_hold", 32'(gamma_page_o), 32'd0);
    tick(6);
    checkOutput("t4_page_hold2", 32'(gamma_page_o), 32'd0);
    checkOutput("t4_boost_hold", 32'(en_gamma_boost_o), 32'd0);
    vsyncFall();
    checkOutput("t4_pend_apply", 32'(switch_pend_o), 32'd1);
    tick(1);
    checkOutput("t4_pend_clr", 32'(switch_pend_o), 32'd0);
    checkOutput("t4_page_e1", 32'(gamma_page_o), 32'd0);
    tick(1);
    checkOutput("t4_page", 32'(gamma_page_o), 32'd2);
    checkOutput("t4_boost", 32'(en_gamma_boost_o), 32'd1);

    // T5: back to bypass, revert before vsync, then 7 -> page 6
    gammaparams_i = 4'h5;
    tick(2);
    checkOutput("t5_pend_off", 32'(switch_pend_o), 32'd1);
    checkOutput("t5_page_keep", 32'(gamma_page_o), 32'd2);
    vsyncFall();
    tick(2);
    checkOutput("t5_byp_page", 32'(gamma_page_o), 32'd0);
    checkOutput("t5_byp_boost", 32'(en_gamma_boost_o), 32'd0);
    gammaparams_i = 4'h7;
    tick(2);
    checkOutput("t5_pend7", 32'(switch_pend_o), 32'd1);
    gammaparams_i = 4'h5;
    tick(2);
    checkOutput("t5_revert_pend", 32'(switch_pend_o), 32'd0);
    tick(8);
    checkOutput("t5_revert_boost", 32'(en_gamma_boost_o), 32'd0);
    gammaparams_i = 4'h7;
    tick(2);
    vsyncFall();
    tick(2);
    checkOutput("t5_page6", 32'(gamma_page_o), 32'd6);
    checkOutput("t5_boost6", 32'(en_gamma_boost_o), 32'd1);
    checkOutput("t5_pend_done", 32'(switch_pend_o), 32'd0);

    // T6: timeout with no video, then reset while pending
    vid_period = 0;
    tick(3);
    gammaparams_i = 4'h0;
    tick(17);
    checkOutput("t6_pend_late", 32'(switch_pend_o), 32'd1);
    checkOutput("t6_page_late", 32'(gamma_page_o), 32'd6);
    tick(1);
    checkOutput("t6_pend_clr", 32'(switch_pend_o), 32'd0);
    checkOutput("t6_page_e17", 32'(gamma_page_o), 32'd6);
    tick(1);
    checkOutput("t6_page0", 32'(gamma_page_o), 32'd0);
    checkOutput("t6_boost0", 32'(en_gamma_boost_o), 32'd1);
    gammaparams_i = 4'h3;
    tick(3);
    checkOutput("t6_pend3", 32'(switch_pend_o), 32'd1);
    nRST = 1'b0;
    tick(1);
    checkOutput("t6_rst_pend", 32'(switch_pend_o), 32'd0);
    checkOutput("t6_rst_boost", 32'(en_gamma_boost_o), 32'd0);
    gammaparams_i = 4'h5;
    tick(2);
    nRST = 1'b1;
    tick(4);
    checkOutput("t6_post_pend", 32'(switch_pend_o), 32'd0);
    checkOutput("t6_post_boost", 32'(en_gamma_boost_o), 32'd0);

    // Reset with queued writes drops them
    vid_period = 3;
    tick(8);
    base = writes_seen;
    applyStimulus(10'h0F0, 7'h0F);
    applyStimulus(10'h0F1, 7'h1E);
    nRST = 1'b0;
    tick(2);
    nRST = 1'b1;
    vid_period = 4;
    tick(24);
    checkOutput("drop_writes", 32'(writes_seen - base), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
